// File: rtl/soc_frame_sender.sv
// ---------------------------------------------------------------------------
// soc_frame_sender
//
// Purpose:
//   Managing-node side of the POWERLINK Start-of-Cycle handshake. When an
//   upstream request (time_to_soc) is pending and the inter-frame gap has
//   elapsed, a SoC frame is assembled from a snapshot of NetTime,
//   RelativeTime and the MC/PS flags and streamed byte-wise to the MAC TX
//   path over a valid/ready interface. Completion is signalled with a
//   one-cycle send_done pulse, after which the 64-bit RelativeTime register
//   advances by rel_step.
//
// Parameters:
//   SRC_MAC    source MAC address, sent MSB first
//   NODE_ID    EPL source node ID
//   FRAME_LEN  bytes sent without FCS, legal range 38..64 (tail is zero)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   time_to_soc     level request to send a SoC, held until send_done
//   time_out_end    inter-frame gap elapsed
//   net_time        NetTime, sampled at frame launch
//   rel_step        RelativeTime increment per sent SoC (zero-extended)
//   rel_time_init   RelativeTime load value
//   rel_time_load   one-cycle pulse loading rel_time_init
//   flag_mc/ps      SoC flags, sampled at frame launch
//   tx_data         frame byte
//   tx_valid        tx_data valid
//   tx_last         final byte marker, qualified by tx_valid
//   tx_ready        MAC accepts the byte this cycle
//   send_done       one-cycle pulse once the whole frame is accepted
//   relative_time   current RelativeTime register
//   busy            FSM not idle
//
// Optional feature (macro SOC_TX_STATS_EN):
//   soc_count       saturating count of sent SoCs
//   late_count      saturating count of launches that had to wait for the gap
// ---------------------------------------------------------------------------
module soc_frame_sender #(
  parameter logic [47:0] SRC_MAC   = 48'h00_11_1E_00_00_F0,
  parameter logic [7:0]  NODE_ID   = 8'hF0,
  parameter int          FRAME_LEN = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_to_soc,
  input  logic        time_out_end,
  input  logic [63:0] net_time,
  input  logic [31:0] rel_step,
  input  logic [63:0] rel_time_init,
  input  logic        rel_time_load,
  input  logic        flag_mc,
  input  logic        flag_ps,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_last,
  input  logic        tx_ready,
  output logic        send_done,
  output logic [63:0] relative_time,
`ifdef SOC_TX_STATS_EN
  output logic [31:0] soc_count,
  output logic [15:0] late_count,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GAP,
    SEND,
    DONE,
    HOLD
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

  state_t      state;
  logic [5:0]  byte_idx;
  logic [63:0] net_snap;
  logic [63:0] rel_snap;
  logic        mc_snap;
  logic        ps_snap;

  logic [5:0]  next_idx;
  logic [7:0]  next_byte;

  // Byte that follows the one currently on the bus. tx_data is registered,
  // so the map is evaluated one index ahead and loaded on acceptance. Byte 0
  // is a constant and is loaded directly at launch, before the snapshot
  // registers hold their new values.
  always_comb begin
    next_idx  = byte_idx + 6'd1;
    next_byte = 8'h00;
    case (next_idx)
      6'd0:  next_byte = 8'h01;
      6'd1:  next_byte = 8'h11;
      6'd2:  next_byte = 8'h1E;
      6'd3:  next_byte = 8'h00;
      6'd4:  next_byte = 8'h00;
      6'd5:  next_byte = 8'h01;
      6'd6:  next_byte = SRC_MAC[47:40];
      6'd7:  next_byte = SRC_MAC[39:32];
      6'd8:  next_byte = SRC_MAC[31:24];
      6'd9:  next_byte = SRC_MAC[23:16];
      6'd10: next_byte = SRC_MAC[15:8];
      6'd11: next_byte = SRC_MAC[7:0];
      6'd12: next_byte = 8'h88;
      6'd13: next_byte = 8'hAB;
      6'd14: next_byte = 8'h01;
      6'd15: next_byte = 8'hFF;
      6'd16: next_byte = NODE_ID;
      6'd19: next_byte = {mc_snap, ps_snap, 6'b0};
      6'd22: next_byte = net_snap[7:0];
      6'd23: next_byte = net_snap[15:8];
      6'd24: next_byte = net_snap[23:16];
      6'd25: next_byte = net_snap[31:24];
      6'd26: next_byte = net_snap[39:32];
      6'd27: next_byte = net_snap[47:40];
      6'd28: next_byte = net_snap[55:48];
      6'd29: next_byte = net_snap[63:56];
      6'd30: next_byte = rel_snap[7:0];
      6'd31: next_byte = rel_snap[15:8];
      6'd32: next_byte = rel_snap[23:16];
      6'd33: next_byte = rel_snap[31:24];
      6'd34: next_byte = rel_snap[39:32];
      6'd35: next_byte = rel_snap[47:40];
      6'd36: next_byte = rel_snap[55:48];
      6'd37: next_byte = rel_snap[63:56];
      default: next_byte = 8'h00;
    endcase
  end

  // Frame FSM with registered outputs and the RelativeTime register.
  // send_done is high exactly while the FSM sits in DONE. HOLD keeps the
  // still-high request level from launching a second frame; a fresh rising
  // request is needed. A RelativeTime load always beats the post-frame
  // increment, while a frame already launched keeps its snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      byte_idx      <= 6'd0;
      tx_data       <= 8'h00;
      tx_valid      <= 1'b0;
      tx_last       <= 1'b0;
      send_done     <= 1'b0;
      busy          <= 1'b0;
      net_snap      <= 64'd0;
      rel_snap      <= 64'd0;
      mc_snap       <= 1'b0;
      ps_snap       <= 1'b0;
      relative_time <= 64'd0;
    end else begin
      send_done <= 1'b0;
      case (state)
        IDLE: begin
          if (time_to_soc) begin
            state <= WAIT_GAP;
            busy  <= 1'b1;
          end
        end
        WAIT_GAP: begin
          if (time_out_end) begin
            net_snap <= net_time;
            rel_snap <= relative_time;
            mc_snap  <= flag_mc;
            ps_snap  <= flag_ps;
            byte_idx <= 6'd0;
            tx_data  <= 8'h01;
            tx_valid <= 1'b1;
            tx_last  <= 1'b0;
            state    <= SEND;
          end else if (!time_to_soc) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (byte_idx == LAST_IDX) begin
              tx_valid  <= 1'b0;
              tx_last   <= 1'b0;
              tx_data   <= 8'h00;
              send_done <= 1'b1;
              state     <= DONE;
            end else begin
              byte_idx <= next_idx;
              tx_data  <= next_byte;
              tx_last  <= (next_idx == LAST_IDX);
            end
          end
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!time_to_soc) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (rel_time_load) begin
        relative_time <= rel_time_init;
      end else if (state == DONE) begin
        relative_time <= relative_time + {32'd0, rel_step};
      end
    end
  end

`ifdef SOC_TX_STATS_EN
  logic gap_late;

  // Statistics counters. gap_late records that the FSM spent at least one
  // cycle in WAIT_GAP without the gap having elapsed, which is exactly the
  // case where WAIT_GAP lasts more than one cycle before launch. It is
  // cleared in IDLE so every request starts fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      soc_count  <= 32'd0;
      late_count <= 16'd0;
      gap_late   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        gap_late <= 1'b0;
      end else if (state == WAIT_GAP && !time_out_end) begin
        gap_late <= 1'b1;
      end

      if (state == WAIT_GAP && time_out_end && gap_late && late_count != 16'hFFFF) begin
        late_count <= late_count + 16'd1;
      end

      if (state == DONE && soc_count != 32'hFFFF_FFFF) begin
        soc_count <= soc_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_soc_frame_sender.sv
// ---------------------------------------------------------------------------
// tb_soc_frame_sender
//
// Purpose:
//   Self-checking bench for soc_frame_sender. Expected frames are built from
//   an independent byte map and pushed to a scoreboard queue when a request
//   is issued; a negedge monitor pops and compares every accepted byte.
//   Scenario tasks check reset state, timing, handshake and RelativeTime
//   behaviour inline. Statistics outputs are checked when SOC_TX_STATS_EN
//   is defined.
// ---------------------------------------------------------------------------
module tb_soc_frame_sender;

  localparam logic [47:0] SRC_MAC   = 48'h00_11_1E_00_00_F0;
  localparam logic [7:0]  NODE_ID   = 8'hF0;
  localparam int          FRAME_LEN = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        time_to_soc = 1'b0;
  logic        time_out_end = 1'b0;
  logic [63:0] net_time = 64'd0;
  logic [31:0] rel_step = 32'd0;
  logic [63:0] rel_time_init = 64'd0;
  logic        rel_time_load = 1'b0;
  logic        flag_mc = 1'b0;
  logic        flag_ps = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready = 1'b0;
  logic        send_done;
  logic [63:0] relative_time;
  logic        busy;
`ifdef SOC_TX_STATS_EN
  logic [31:0] soc_count;
  logic [15:0] late_count;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [63:0] model_rel = 64'd0;
  int          model_soc = 0;
  int          model_late = 0;

  soc_frame_sender #(
    .SRC_MAC  (SRC_MAC),
    .NODE_ID  (NODE_ID),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .time_to_soc  (time_to_soc),
    .time_out_end (time_out_end),
    .net_time     (net_time),
    .rel_step     (rel_step),
    .rel_time_init(rel_time_init),
    .rel_time_load(rel_time_load),
    .flag_mc      (flag_mc),
    .flag_ps      (flag_ps),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .send_done    (send_done),
    .relative_time(relative_time),
`ifdef SOC_TX_STATS_EN
    .soc_count    (soc_count),
    .late_count   (late_count),
`endif
    .busy         (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Scoreboard monitor: every byte handed over (valid and ready while not
  // in reset) must match the head of the expected queue, including tx_last.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && tx_valid && tx_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_byte: got %02h, no byte expected", tx_data);
      end else begin
        e = sb.pop_front();
        if (tx_data !== e.data || tx_last !== e.last) begin
          errors++;
          $display("[TB] FAIL frame_byte (%0d left): got data %02h last %b, expected data %02h last %b",
                   sb.size(), tx_data, tx_last, e.data, e.last);
        end
      end
    end
  end

  // Runaway guard for the whole run.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to just after the next active edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Builds the expected SoC frame from the byte map and queues it.
  task automatic push_frame(input logic [63:0] nt, input logic [63:0] rt,
                            input logic mc, input logic ps);
    logic [7:0]  b [0:FRAME_LEN-1];
    logic [47:0] mac;
    mac = SRC_MAC;
    for (int i = 0; i < FRAME_LEN; i++) b[i] = 8'h00;
    b[0] = 8'h01; b[1] = 8'h11; b[2] = 8'h1E; b[3] = 8'h00; b[4] = 8'h00; b[5] = 8'h01;
    for (int i = 0; i < 6; i++) b[6+i] = mac[47-8*i -: 8];
    b[12] = 8'h88; b[13] = 8'hAB; b[14] = 8'h01; b[15] = 8'hFF; b[16] = NODE_ID;
    b[19] = {mc, ps, 6'b0};
    for (int i = 0; i < 8; i++) begin
      b[22+i] = nt[8*i +: 8];
      b[30+i] = rt[8*i +: 8];
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      sb.push_back(exp_t'({b[i], (i == FRAME_LEN - 1)}));
    end
  endtask

  // Waits, within a cycle budget, for send_done; leaves the bench in the
  // DONE cycle when it is seen.
  task automatic wait_send_done(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      step();
      cycles++;
      if (send_done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    rst = 1'b0;
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %b, expected 0", tx_valid); end
    vectors++; if (tx_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_last: got %b, expected 0", tx_last); end
    vectors++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %02h, expected 00", tx_data); end
    vectors++; if (send_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_send_done: got %b, expected 0", send_done); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    vectors++; if (relative_time !== 64'd0) begin errors++; $display("[TB] FAIL reset_relative_time: got %h, expected 0", relative_time); end
`ifdef SOC_TX_STATS_EN
    vectors++; if (soc_count !== 32'd0 || late_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_stats: got %0d/%0d, expected 0/0", soc_count, late_count); end
`endif
  endtask

  task automatic test_basic_frame();
    int cycles;
    bit seen;
    rel_step      = 32'h0000_0250;
    rel_time_init = 64'h0000_0000_0000_1000;
    rel_time_load = 1'b1;
    step();
    rel_time_load = 1'b0;
    model_rel = 64'h0000_0000_0000_1000;
    vectors++; if (relative_time !== model_rel) begin errors++; $display("[TB] FAIL basic_load: got %h, expected %h", relative_time, model_rel); end

    net_time     = 64'h0102_0304_0506_0708;
    flag_mc      = 1'b1;
    flag_ps      = 1'b0;
    tx_ready     = 1'b1;
    time_out_end = 1'b1;
    push_frame(net_time, model_rel, flag_mc, flag_ps);
    time_to_soc = 1'b1;
    step();
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_wait_gap_valid: got %b, expected 0", tx_valid); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b, expected 1", busy); end
    step();
    vectors++; if (tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_first_valid: got %b, expected 1", tx_valid); end
    // Inputs changing mid-frame must not leak into the frame in flight.
    net_time = {$urandom, $urandom};
    flag_mc  = 1'b0;
    flag_ps  = 1'b1;

    wait_send_done(200, cycles, seen);
    vectors++; if (!seen) begin errors++; $display("[TB] FAIL basic_send_done_timeout: got none, expected pulse"); end
    vectors++; if (cycles !== FRAME_LEN) begin errors++; $display("[TB] FAIL basic_frame_cycles: got %0d, expected %0d", cycles, FRAME_LEN); end
    step();
    vectors++; if (send_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_width: got %b, expected 0", send_done); end
    model_rel = model_rel + {32'd0, rel_step};
    model_soc++;
    vectors++; if (relative_time !== model_rel) begin errors++; $display("[TB] FAIL basic_rel_inc: got %h, expected %h", relative_time, model_rel); end
    time_to_soc  = 1'b0;
    time_out_end = 1'b0;
    repeat (2) step();
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: got busy %b, expected 0", busy); end
    vectors++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL basic_bytes_left: got %0d, expected 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    logic [7:0] prev_data;
    logic       prev_valid, prev_ready;
    bit         seen;
    int         stalls;
    pat    = 4'b1001;
    seen   = 1'b0;
    stalls = 0;
    net_time     = 64'hDEAD_BEEF_CAFE_F00D;
    flag_mc      = 1'b0;
    flag_ps      = 1'b1;
    time_out_end = 1'b1;
    tx_ready     = pat[0];
    push_frame(net_time, model_rel, flag_mc, flag_ps);
    time_to_soc = 1'b1;
    for (int n = 1; n < 400 && !seen; n++) begin
      prev_data  = tx_data;
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      step();
      if (prev_valid && !prev_ready) begin
        stalls++;
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          errors++;
          $display("[TB] FAIL stall_hold: got valid %b data %02h, expected valid 1 data %02h", tx_valid, tx_data, prev_data);
        end
      end
      if (send_done === 1'b1) seen = 1'b1;
      tx_ready = pat[n % 4];
    end
    vectors++; if (!seen) begin errors++; $display("[TB] FAIL bp_send_done_timeout: got none, expected pulse"); end
    vectors++; if (stalls < FRAME_LEN / 2) begin errors++; $display("[TB] FAIL bp_stall_count: got %0d, expected at least %0d", stalls, FRAME_LEN / 2); end
    step();
    model_rel = model_rel + {32'd0, rel_step};
    model_soc++;
    vectors++; if (relative_time !== model_rel) begin errors++; $display("[TB] FAIL bp_rel_inc: got %h, expected %h", relative_time, model_rel); end
    vectors++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL bp_bytes_left: got %0d, expected 0", sb.size()); end
    time_to_soc = 1'b0;
    tx_ready    = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_gap_wait();
    int cycles;
    bit seen;
    net_time     = 64'h1122_3344_5566_7788;
    flag_mc      = 1'b1;
    flag_ps      = 1'b1;
    time_out_end = 1'b0;
    tx_ready     = 1'b1;
    push_frame(net_time, model_rel, flag_mc, flag_ps);
    time_to_soc = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL gap_no_valid cycle %0d: got %b, expected 0", i, tx_valid); end
    end
    time_out_end = 1'b1;
    step();
    vectors++; if (tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL gap_launch: got %b, expected 1", tx_valid); end
    model_late++;
    wait_send_done(200, cycles, seen);
    vectors++; if (!seen) begin errors++; $display("[TB] FAIL gap_send_done_timeout: got none, expected pulse"); end
    step();
    model_rel = model_rel + {32'd0, rel_step};
    model_soc++;
    vectors++; if (relative_time !== model_rel) begin errors++; $display("[TB] FAIL gap_rel_inc: got %h, expected %h", relative_time, model_rel); end
`ifdef SOC_TX_STATS_EN
    vectors++; if (late_count !== 16'(model_late)) begin errors++; $display("[TB] FAIL gap_late_count: got %0d, expected %0d", late_count, model_late); end
    vectors++; if (soc_count !== 32'(model_soc)) begin errors++; $display("[TB] FAIL gap_soc_count: got %0d, expected %0d", soc_count, model_soc); end
`endif
    time_to_soc = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_no_retrigger();
    int cycles;
    bit seen;
    net_time     = 64'h0F0E_0D0C_0B0A_0908;
    flag_mc      = 1'b0;
    flag_ps      = 1'b0;
    time_out_end = 1'b1;
    tx_ready     = 1'b1;
    push_frame(net_time, model_rel, flag_mc, flag_ps);
    time_to_soc = 1'b1;
    wait_send_done(200, cycles, seen);
    vectors++; if (!seen) begin errors++; $display("[TB] FAIL nr_first_timeout: got none, expected pulse"); end
    model_rel = model_rel + {32'd0, rel_step};
    model_soc++;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL nr_hold cycle %0d: got valid %b busy %b, expected valid 0 busy 1", i, tx_valid, busy); end
    end
    time_to_soc = 1'b0;
    repeat (2) step();
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL nr_idle: got busy %b, expected 0", busy); end
    push_frame(net_time, model_rel, flag_mc, flag_ps);
    time_to_soc = 1'b1;
    wait_send_done(200, cycles, seen);
    vectors++; if (!seen) begin errors++; $display("[TB] FAIL nr_second_timeout: got none, expected pulse"); end
    step();
    model_rel = model_rel + {32'd0, rel_step};
    model_soc++;
    vectors++; if (relative_time !== model_rel) begin errors++; $display("[TB] FAIL nr_rel_inc: got %h, expected %h", relative_time, model_rel); end
    time_to_soc = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_mid_frame_reset();
    net_time     = 64'hA5A5_5A5A_0123_4567;
    time_out_end = 1'b1;
    tx_ready     = 1'b1;
    push_frame(net_time, model_rel, flag_mc, flag_ps);
    time_to_soc = 1'b1;
    repeat (2) step();
    repeat (25) step();
    vectors++; if (tx_valid !== 1'b1 || sb.size() !== FRAME_LEN - 25) begin errors++; $display("[TB] FAIL mr_position: got valid %b left %0d, expected valid 1 left %0d", tx_valid, sb.size(), FRAME_LEN - 25); end
    rst         = 1'b1;
    time_to_soc = 1'b0;
    step();
    rst = 1'b0;
    sb.delete();
    model_rel  = 64'd0;
    model_soc  = 0;
    model_late = 0;
    vectors++; if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mr_valid_drop: got %b, expected 0", tx_valid); end
    vectors++; if (relative_time !== 64'd0) begin errors++; $display("[TB] FAIL mr_rel_clear: got %h, expected 0", relative_time); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mr_busy: got %b, expected 0", busy); end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (send_done !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL mr_quiet cycle %0d: got done %b valid %b, expected 0 0", i, send_done, tx_valid); end
    end
`ifdef SOC_TX_STATS_EN
    vectors++; if (soc_count !== 32'd0 || late_count !== 16'd0) begin errors++; $display("[TB] FAIL mr_stats: got %0d/%0d, expected 0/0", soc_count, late_count); end
`endif
  endtask

  task automatic test_load_vs_increment();
    int cycles;
    bit seen;
    net_time     = 64'h7766_5544_3322_1100;
    flag_mc      = 1'b1;
    flag_ps      = 1'b0;
    time_out_end = 1'b1;
    tx_ready     = 1'b1;
    push_frame(net_time, model_rel, flag_mc, flag_ps);
    time_to_soc = 1'b1;
    wait_send_done(200, cycles, seen);
    vectors++; if (!seen) begin errors++; $display("[TB] FAIL lv_first_timeout: got none, expected pulse"); end
    model_soc++;
    // Load lands in the DONE cycle and must override the increment.
    rel_time_init = 64'hFFFF_FFFF_FFFF_FFFF;
    rel_time_load = 1'b1;
    step();
    rel_time_load = 1'b0;
    model_rel = 64'hFFFF_FFFF_FFFF_FFFF;
    vectors++; if (relative_time !== model_rel) begin errors++; $display("[TB] FAIL lv_load_wins: got %h, expected %h", relative_time, model_rel); end
    time_to_soc = 1'b0;
    repeat (2) step();
    push_frame(net_time, model_rel, flag_mc, flag_ps);
    time_to_soc = 1'b1;
    wait_send_done(200, cycles, seen);
    vectors++; if (!seen) begin errors++; $display("[TB] FAIL lv_second_timeout: got none, expected pulse"); end
    step();
    model_rel = model_rel + {32'd0, rel_step};
    model_soc++;
    vectors++; if (relative_time !== model_rel) begin errors++; $display("[TB] FAIL lv_wrap: got %h, expected %h", relative_time, model_rel); end
    vectors++; if (sb.size() !== 0) begin errors++; $display("[TB] FAIL lv_bytes_left: got %0d, expected 0", sb.size()); end
`ifdef SOC_TX_STATS_EN
    vectors++; if (soc_count !== 32'(model_soc) || late_count !== 16'(model_late)) begin errors++; $display("[TB] FAIL lv_stats: got %0d/%0d, expected %0d/%0d", soc_count, late_count, model_soc, model_late); end
`endif
    time_to_soc = 1'b0;
    repeat (2) step();
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_gap_wait();
    test_no_retrigger();
    test_mid_frame_reset();
    test_load_vs_increment();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
